mul_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M multiply path. It accepts one MUL/MULH/MULHSU/MULHU request through a valid/ready handshake. It generates radix-4 Booth partial products two per cycle and folds them into a running sum/carry pair through one 4:2 compressor row. It then resolves sum+carry in a final carry-propagate cycle and returns the selected 32-bit half to the execute stage with a destination tag.

---
 rtl/mul_pkg.sv | 40 ++++
 rtl/booth_pp_gen.sv | 35 +++
 rtl/compress_42.sv | 28 ++
 rtl/mul_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types for the sequential RV32M multiplier: funct codes, FSM states, Booth digits.
// Pure declarations; no timing or flow control of its own.
package mul_pkg;

   localparam int MUL_XLEN   = 32;
   localparam int NUM_DIGITS = (MUL_XLEN + 2) / 2;
   localparam int NUM_STEPS  = (NUM_DIGITS + 1) / 2;

   localparam logic [1:0] MUL_LO = 2'b00;
   localparam logic [1:0] MULH   = 2'b01;
   localparam logic [1:0] MULHSU = 2'b10;
   localparam logic [1:0] MULHU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPRESS = 2'd1,
      RESOLVE  = 2'd2,
      DONE     = 2'd3
   } mul_state_e;

   typedef enum logic [2:0] {
      BD_ZERO = 3'd0,
      BD_POS1 = 3'd1,
      BD_POS2 = 3'd2,
      BD_NEG1 = 3'd3,
      BD_NEG2 = 3'd4
   } booth_digit_e;

   // Radix-4 recode of the window {m[2i+1], m[2i], m[2i-1]}.
   function automatic booth_digit_e booth_decode(input logic [2:0] win);
      case (win)
         3'b001, 3'b010: return BD_POS1;
         3'b011:         return BD_POS2;
         3'b100:         return BD_NEG2;
         3'b101, 3'b110: return BD_NEG1;
         default:        return BD_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: digit * multiplicand, sign-extended and shifted by 2*idx.
// Purely combinational; no handshake.
module booth_pp_gen
   import mul_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 5
) (
   input  logic [XLEN:0]     i_mcand,
   input  logic [2:0]        i_window,
   input  logic [IDX_W-1:0]  i_idx,
   output logic [2*XLEN-1:0] o_pp
);

   booth_digit_e      w_dig;
   logic [2*XLEN-1:0] w_mc;
   logic [2*XLEN-1:0] w_mag;

   assign w_dig = booth_decode(i_window);
   assign w_mc  = {{(XLEN-1){i_mcand[XLEN]}}, i_mcand};

   always_comb begin
      w_mag = '0;
      case (w_dig)
         BD_POS1: w_mag = w_mc;
         BD_POS2: w_mag = w_mc << 1;
         BD_NEG1: w_mag = -w_mc;
         BD_NEG2: w_mag = -(w_mc << 1);
         default: w_mag = '0;
      endcase
   end

   assign o_pp = w_mag << {i_idx, 1'b0};

endmodule

// File: rtl/compress_42.sv
// 4:2 compressor row over 2*LENGTH bits: a+b+c+d+cin == sum + 2*carry (mod 2^(2*LENGTH)).
// Purely combinational; no handshake.
module compress_42 #(
   parameter int LENGTH = 32
) (
   input  logic [2*LENGTH-1:0] i_a,
   input  logic [2*LENGTH-1:0] i_b,
   input  logic [2*LENGTH-1:0] i_c,
   input  logic [2*LENGTH-1:0] i_d,
   input  logic                i_cin,
   output logic [2*LENGTH-1:0] o_sum,
   output logic [2*LENGTH-1:0] o_carry
);

   logic [2*LENGTH-1:0] w_s1;
   logic [2*LENGTH:0]   w_chain;

   assign w_chain[0] = i_cin;

   // First adder's carry ripples one column sideways into the second adder.
   for (genvar g = 0; g < 2*LENGTH; g++) begin : g_col
      assign w_s1[g]      = i_a[g] ^ i_b[g] ^ i_c[g];
      assign w_chain[g+1] = (i_a[g] & i_b[g]) | (i_a[g] & i_c[g]) | (i_b[g] & i_c[g]);
      assign o_sum[g]     = w_s1[g] ^ i_d[g] ^ w_chain[g];
      assign o_carry[g]   = (w_s1[g] & i_d[g]) | (w_s1[g] & w_chain[g]) | (i_d[g] & w_chain[g]);
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiplier: 9 Booth/4:2 steps plus a CPA cycle; result 10 edges after accept (1 if an operand is zero).
// Single request in flight; result held in DONE until out_ready, no new request accepted until then.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_funct,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int N_DIG = (XLEN + 2) / 2;
   localparam int N_STEP = (N_DIG + 1) / 2;
   localparam int CNT_W = $clog2(N_STEP);
   localparam int IDX_W = CNT_W + 1;

   mul_state_e        r_state, w_next;
   logic [CNT_W-1:0]  r_count;
   logic [XLEN:0]     r_mcand;
   logic [XLEN+1:0]   r_mplier;
   logic [1:0]        r_funct;
   logic [TAG_W-1:0]  r_tag;
   logic [2*XLEN-1:0] r_sum, r_carry;
   logic [XLEN-1:0]   r_result;
   logic [TAG_W-1:0]  r_out_tag;

   logic              w_accept, w_zero, w_last, w_sx1, w_sx2;
   logic [XLEN+4:0]   w_win_src;
   logic [IDX_W-1:0]  w_idx0, w_idx1;
   logic [2:0]        w_win0, w_win1;
   logic [2*XLEN-1:0] w_pp0, w_pp1, w_sum, w_carry, w_prod;

   assign w_accept = in_valid & in_ready;
   assign w_zero   = (in_rs1 == '0) | (in_rs2 == '0);
   assign w_last   = (r_count == CNT_W'(N_STEP - 1));
   assign w_sx1    = (in_funct == MULH) | (in_funct == MULHSU);
   assign w_sx2    = (in_funct == MULH);

   // Two extra sign bits make the window past the last digit recode to zero.
   assign w_win_src = {{2{r_mplier[XLEN+1]}}, r_mplier, 1'b0};
   assign w_idx0    = {r_count, 1'b0};
   assign w_idx1    = {r_count, 1'b1};
   assign w_win0    = w_win_src[{w_idx0, 1'b0} +: 3];
   assign w_win1    = w_win_src[{w_idx1, 1'b0} +: 3];

   booth_pp_gen #(.XLEN(XLEN), .IDX_W(IDX_W)) u_pp0 (
      .i_mcand(r_mcand), .i_window(w_win0), .i_idx(w_idx0), .o_pp(w_pp0)
   );

   booth_pp_gen #(.XLEN(XLEN), .IDX_W(IDX_W)) u_pp1 (
      .i_mcand(r_mcand), .i_window(w_win1), .i_idx(w_idx1), .o_pp(w_pp1)
   );

   compress_42 #(.LENGTH(XLEN)) u_cmp (
      .i_a(r_sum), .i_b(r_carry), .i_c(w_pp0), .i_d(w_pp1), .i_cin(1'b0),
      .o_sum(w_sum), .o_carry(w_carry)
   );

   assign w_prod = r_sum + r_carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Zero operands skip compression; RESOLVE of the cleared sum/carry yields 0.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:     if (w_accept) w_next = w_zero ? RESOLVE : COMPRESS;
            COMPRESS: if (w_last) w_next = RESOLVE;
            RESOLVE:  w_next = DONE;
            DONE:     if (out_ready) w_next = IDLE;
            default:  w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == IDLE) & ~flush;
      out_valid = (r_state == DONE);
      busy      = (r_state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_funct   <= MUL_LO;
         r_tag     <= '0;
         r_sum     <= '0;
         r_carry   <= '0;
         r_result  <= '0;
         r_out_tag <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_mcand  <= {w_sx1 & in_rs1[XLEN-1], in_rs1};
               r_mplier <= {{2{w_sx2 & in_rs2[XLEN-1]}}, in_rs2};
               r_funct  <= in_funct;
               r_tag    <= in_tag;
               r_count  <= '0;
               r_sum    <= '0;
               r_carry  <= '0;
            end
            COMPRESS: begin
               r_sum   <= w_sum;
               r_carry <= w_carry << 1;
               r_count <= r_count + CNT_W'(1);
            end
            RESOLVE: begin
               r_result  <= (r_funct == MUL_LO) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
               r_out_tag <= r_tag;
            end
            default: ;
         endcase
      end
   end

   assign out_result = r_result;
   assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed corner cases plus randomized requests against a 64-bit product model.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  in_funct;
   logic [31:0] in_rs1, in_rs2;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: full 64-bit product of the architecturally extended operands.
   function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] x, y, p;
      x = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      y = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p = x * y;
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      int w;
      @(negedge clk);
      in_valid = 1'b1; in_funct = f; in_rs1 = a; in_rs2 = b; in_tag = t;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", 64'(w < 40), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_funct = 2'($urandom);
      in_rs1   = $urandom;
      in_rs2   = $urandom;
      in_tag   = 5'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 40);
   endtask

   task automatic finish_out(input string tag, input logic [31:0] er, input logic [4:0] et, input int stall);
      chk({tag, "_result"}, 64'(out_result), 64'(er));
      chk({tag, "_tag"}, 64'(out_tag), 64'(et));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
         chk({tag, "_hold_res"}, 64'(out_result), 64'(er));
         chk({tag, "_hold_tag"}, 64'(out_tag), 64'(et));
         chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_released"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   logic [1:0]  t2_f [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [31:0] t2_a [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] t2_b [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] t2_e [4] = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'h00000001};

   initial begin
      int          lat;
      int          seen;
      logic [1:0]  f;
      logic [31:0] a, b;
      logic [4:0]  t;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_funct = 2'b00; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
      #2;
      chk("reset_state", 64'({out_valid, busy, in_ready}), 64'b001);
      chk("reset_data", 64'({out_result, out_tag}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic MUL with latency check.
      send(2'b00, 32'd7, 32'd6, 5'd19);
      wait_out(lat);
      chk("mul7x6_lat", 64'(lat), 64'd10);
      finish_out("mul7x6", 32'd42, 5'd19, 0);

      // Sign-handling corners.
      for (int i = 0; i < 4; i++) begin
         send(t2_f[i], t2_a[i], t2_b[i], 5'(i + 1));
         wait_out(lat);
         chk("corner_lat", 64'(lat), 64'd10);
         chk("corner_model", 64'(ref_mul(t2_f[i], t2_a[i], t2_b[i])), 64'(t2_e[i]));
         finish_out("corner", t2_e[i], 5'(i + 1), 0);
      end

      // Zero shortcut; a waiting request must not be taken while in DONE.
      send(2'b00, 32'd0, 32'h12345678, 5'd3);
      wait_out(lat);
      chk("zero_lat", 64'(lat), 64'd1);
      in_valid = 1'b1; in_funct = 2'b00; in_rs1 = 32'd5; in_rs2 = 32'd5;
      for (int i = 0; i < 3; i++) begin
         chk("zero_block_rdy", 64'({in_ready, out_valid}), 64'b01);
         @(negedge clk);
      end
      in_valid = 1'b0;
      finish_out("zero", 32'd0, 5'd3, 0);

      // Back-pressure for five cycles.
      a = $urandom; b = $urandom;
      send(2'b11, a, b, 5'd27);
      wait_out(lat);
      finish_out("bp", ref_mul(2'b11, a, b), 5'd27, 5);

      // Flush after four compression steps.
      send(2'b01, 32'h1234, 32'h5678, 5'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      chk("flush_rdy", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle", 64'({busy, out_valid, in_ready}), 64'b001);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | int'(out_valid);
      end
      chk("flush_no_out", 64'(seen), 64'd0);
      send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd30);
      wait_out(lat);
      chk("post_flush_lat", 64'(lat), 64'd10);
      finish_out("post_flush", 32'hFFFFFFFE, 5'd30, 0);

      // Asynchronous reset while in RESOLVE.
      send(2'b01, 32'hDEADBEEF, 32'h0BADF00D, 5'd9);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", 64'({busy, out_valid}), 64'b10);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_ctrl", 64'({out_valid, busy, in_ready}), 64'b001);
      chk("async_rst_data", 64'({out_result, out_tag}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | int'(out_valid);
      end
      chk("rst_no_out", 64'(seen), 64'd0);

      // Randomized requests with random consumer stalls.
      for (int n = 0; n < 1000; n++) begin
         f = 2'($urandom);
         a = $urandom;
         b = $urandom;
         t = 5'($urandom);
         case ($urandom_range(0, 9))
            0: a = 32'd0;
            1: b = 32'd0;
            2: a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
            3: b = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
            default: ;
         endcase
         send(f, a, b, t);
         wait_out(lat);
         chk("rand_lat", 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'd10);
         finish_out("rand", ref_mul(f, a, b), t, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
